wb_load_scheduler: RTL



---
 rtl/wb_sched_pkg.sv | 21 ++
 rtl/wb_rr_arbiter.sv | 35 +++
 rtl/wb_load_scheduler.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/wb_sched_pkg.sv
// ---------------------------------------------------------------------------
// wb_sched_pkg
// Shared definitions for the weight-buffer load scheduler.
//   - sched_state_e : scheduler FSM states
//   - DEF_*         : default parameter values used by the scheduler top
// ---------------------------------------------------------------------------
package wb_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        START = 3'd2,
        BUSY  = 3'd3,
        RESP  = 3'd4
    } sched_state_e;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_CNTW    = 16;
    localparam int DEF_TIMEOUT = 1024;

endpackage : wb_sched_pkg

// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
// Combinational rotating-priority arbiter. The request at index `ptr` has the
// highest priority, then ptr+1, ... wrapping modulo NUM_REQ.
// Ports:
//   req : request vector, one bit per client
//   ptr : index of the highest-priority client this cycle
//   gnt : one-hot grant (all zero when no request is set)
// ---------------------------------------------------------------------------
module wb_rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int PTRW   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTRW-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic found;
    int   idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule : wb_rr_arbiter

// File: rtl/wb_load_scheduler.sv
// ---------------------------------------------------------------------------
// wb_load_scheduler
// Shares one Avalon weight-buffer read master among NUM_REQ clients.
// A granted job runs IDLE -> CLEAR -> START -> BUSY -> RESP -> IDLE.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   req_i             : per-client level request, held until its done_o bit
//   req_addr_i        : flattened per-client base addresses (slice k = client k)
//   grant_o           : one-hot served client, zero in IDLE
//   done_o            : one-cycle completion pulse to the served client
//   err_o             : one-cycle pulse with done_o when the job timed out
//   line_count_o      : lines received in the finished job (valid with done_o)
//   line_valid_o      : registered per-client line strobe
//   line_data_o       : registered line data
//   busy_o            : high outside IDLE
//   rm_base_addr_o    : latched base address to the read master, zero in IDLE
//   rm_clear_o        : read-master address-counter clear pulse (CLEAR)
//   rm_start_o        : read-master start pulse (START)
//   rm_line_valid_i   : line strobe from the read master
//   rm_line_i         : line data from the read master
//   rm_done_i         : read-master completion pulse
//
// Line interface: rm_line_valid_i is a single-cycle strobe with no back-pressure;
// a line is taken exactly in a cycle where the strobe is high and the
// scheduler is in BUSY. Strobes in any other state are dropped.
// ---------------------------------------------------------------------------
module wb_load_scheduler
    import wb_sched_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int BUSWIDTH = 512,
    parameter int ADDRW    = 64,
    parameter int CNTW     = DEF_CNTW,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*ADDRW-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic [NUM_REQ-1:0]       done_o,
    output logic                     err_o,
    output logic [CNTW-1:0]          line_count_o,
    output logic [NUM_REQ-1:0]       line_valid_o,
    output logic [BUSWIDTH-1:0]      line_data_o,
    output logic                     busy_o,
    output logic [ADDRW-1:0]         rm_base_addr_o,
    output logic                     rm_clear_o,
    output logic                     rm_start_o,
    input  logic                     rm_line_valid_i,
    input  logic [BUSWIDTH-1:0]      rm_line_i,
    input  logic                     rm_done_i
);

    localparam int PTRW = $clog2(NUM_REQ);
    localparam int TOW  = $clog2(TIMEOUT + 1);

    sched_state_e        state_q, state_d;
    logic [PTRW-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [ADDRW-1:0]    addr_q, addr_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [TOW-1:0]      to_q, to_d;
    logic                err_q, err_d;
    logic [NUM_REQ-1:0]  line_valid_q, line_valid_d;
    logic [BUSWIDTH-1:0] line_data_q, line_data_d;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [ADDRW-1:0]    arb_addr;
    logic [PTRW-1:0]     served_idx;
    logic                line_acc;
    logic                timeout_hit;

    // ptr_q is the highest-priority index for the next arbitration, so the
    // reset value 0 puts client 0 first and serving client k moves it to k+1.
    wb_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req (req_i),
        .ptr (ptr_q),
        .gnt (arb_gnt)
    );

    always_comb begin
        arb_addr   = '0;
        served_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_gnt[k]) arb_addr = req_addr_i[k*ADDRW +: ADDRW];
            if (grant_q[k]) served_idx = PTRW'(k);
        end
    end

    assign line_acc    = (state_q == BUSY) && rm_line_valid_i;
    // A strobe in the last idle cycle reloads the timer instead of aborting.
    assign timeout_hit = (to_q == TOW'(TIMEOUT - 1)) && !rm_line_valid_i;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|req_i) state_d = CLEAR;
            CLEAR:   state_d = START;
            START:   state_d = BUSY;
            BUSY:    if (rm_done_i || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy_o         = (state_q != IDLE);
        grant_o        = (state_q != IDLE) ? grant_q : '0;
        rm_base_addr_o = (state_q != IDLE) ? addr_q  : '0;
        rm_clear_o     = (state_q == CLEAR);
        rm_start_o     = (state_q == START);
        done_o         = (state_q == RESP) ? grant_q : '0;
        err_o          = (state_q == RESP) && err_q;
        line_count_o   = (state_q == RESP) ? cnt_q   : '0;
        line_valid_o   = line_valid_q;
        line_data_o    = line_data_q;
    end

    // ---------------- Datapath next-state ----------------
    always_comb begin
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        to_d         = to_q;
        err_d        = err_q;
        line_valid_d = line_acc ? grant_q : '0;
        line_data_d  = line_acc ? rm_line_i : line_data_q;

        unique case (state_q)
            IDLE: begin
                if (|req_i) begin
                    grant_d = arb_gnt;
                    addr_d  = arb_addr;
                end
            end
            START: begin
                cnt_d = '0;
                to_d  = '0;
                err_d = 1'b0;
            end
            BUSY: begin
                if (line_acc) begin
                    if (cnt_q != '1) cnt_d = cnt_q + CNTW'(1);
                    to_d = '0;
                end else if (!timeout_hit) begin
                    to_d = to_q + TOW'(1);
                end
                // A done in the timeout cycle still counts as a clean finish.
                if (rm_done_i)        err_d = 1'b0;
                else if (timeout_hit) err_d = 1'b1;
            end
            RESP: begin
                if (int'(served_idx) == NUM_REQ - 1) ptr_d = '0;
                else                                 ptr_d = served_idx + PTRW'(1);
            end
            default: ;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= '0;
            grant_q      <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            to_q         <= '0;
            err_q        <= 1'b0;
            line_valid_q <= '0;
            line_data_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            to_q         <= to_d;
            err_q        <= err_d;
            line_valid_q <= line_valid_d;
            line_data_q  <= line_data_d;
        end
    end

endmodule : wb_load_scheduler
